// File: rtl/anim_scheduler_pkg.sv
// Shared definitions for the bouncing-square frame scheduler.
//   - sched_state_e : scheduler FSM encoding (IDLE=0, RUN=1, PAUSED=2)
//   - *_DEF         : default sizing shared by the top level and the divider
package anim_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } sched_state_e;

    localparam int unsigned N_SQ_DEF    = 3;
    localparam int unsigned DIV_W_DEF   = 4;
    localparam int unsigned FRAME_W_DEF = 16;

endpackage

// File: rtl/anim_divider.sv
// Per-square frame divider: a modulo-max(div,1) counter advanced once per
// processed frame.
//   i_clk   : system clock
//   i_rst   : asynchronous active-low reset
//   i_tick  : one-clock pulse, a frame is being processed
//   i_div   : divisor (0 behaves as 1)
//   o_due   : combinational, high with i_tick when this frame is the square's turn
module anim_divider
    import anim_scheduler_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_due
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last_val;
    logic             at_last;

    always_comb begin
        // A zero divisor collapses to "every frame".
        last_val = (i_div == '0) ? '0 : i_div - DIV_W'(1);
        at_last  = (cnt_q == last_val);
        o_due    = i_tick & at_last;
        cnt_d    = cnt_q;
        if (i_tick) begin
            cnt_d = at_last ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Frame-level sequencer between vga640x480 and the square instances.
// Converts the end-of-frame animate strobe into serialised one-clock update
// pulses, one square per clock, in round-robin start order, with
// run/pause/single-step control.
//   i_clk        : system clock
//   i_rst        : asynchronous active-low reset
//   i_pix_stb    : pixel strobe, qualifies i_animate sampling
//   i_animate    : end-of-frame level from the VGA timing block
//   i_pause      : level, 1 = stop processing new frames
//   i_step       : pulse, while paused allow exactly one more frame
//   o_sq_animate : one-hot (or zero) update pulse per square
//   o_frame      : processed-frame counter (wraps)
//   o_busy       : pulses still pending
//   o_paused     : FSM is in PAUSED
//   o_overrun    : sticky, a frame arrived before the previous one drained
module anim_scheduler
    import anim_scheduler_pkg::*;
#(
    parameter int unsigned          N_SQ    = N_SQ_DEF,
    parameter int unsigned          DIV_W   = DIV_W_DEF,
    parameter logic [N_SQ*DIV_W-1:0] DIVS   = 12'h121,
    parameter int unsigned          FRAME_W = FRAME_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    input  logic               i_animate,
    input  logic               i_pause,
    input  logic               i_step,
    output logic [N_SQ-1:0]    o_sq_animate,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_busy,
    output logic               o_paused,
    output logic               o_overrun
);

    localparam int unsigned IDX_W = (N_SQ > 1) ? $clog2(N_SQ) : 1;

    sched_state_e       state_q, state_d;
    logic               anim_q;
    logic               step_req_q, step_req_d;
    logic [N_SQ-1:0]    pending_q, pending_d;
    logic [N_SQ-1:0]    sq_q, sq_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               overrun_q, overrun_d;

    logic               frame_evt;
    logic               process_frame;
    logic [N_SQ-1:0]    due;
    logic [N_SQ-1:0]    at_or_after;
    logic [N_SQ-1:0]    pick_src;
    logic [N_SQ-1:0]    pick;
    logic [N_SQ-1:0]    pending_left;

    // Rising edge of i_animate as seen on pixel-strobe cycles.
    assign frame_evt = i_pix_stb & i_animate & ~anim_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_SQ; gi++) begin : g_sq
            anim_divider #(
                .DIV_W (DIV_W)
            ) u_div (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_tick (process_frame),
                .i_div  (DIVS[gi*DIV_W +: DIV_W]),
                .o_due  (due[gi])
            );
            assign at_or_after[gi] = (IDX_W'(gi) >= start_q);
        end
    endgenerate

    // Circular priority: lowest pending bit at/after start, else wrap to the
    // lowest pending bit overall. x & -x isolates the lowest set bit.
    always_comb begin
        pick_src     = ((pending_q & at_or_after) != '0) ? (pending_q & at_or_after) : pending_q;
        pick         = pick_src & (~pick_src + N_SQ'(1));
        pending_left = pending_q & ~pick;
    end

    always_comb begin
        state_d       = state_q;
        step_req_d    = step_req_q;
        process_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // First event only aligns the scheduler to the frame cadence.
                step_req_d = 1'b0;
                if (frame_evt) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step_req_d    = 1'b0;
                process_frame = frame_evt;
                if (i_pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (i_step) begin
                    step_req_d = 1'b1;
                end
                if (frame_evt && step_req_q) begin
                    process_frame = 1'b1;
                    step_req_d    = 1'b0;
                end
                if (!i_pause) begin
                    state_d    = ST_RUN;
                    step_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                step_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        sq_d      = pick;
        pending_d = pending_left;
        frame_d   = frame_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        overrun_d = overrun_q;
        if (process_frame) begin
            frame_d   = frame_q + FRAME_W'(1);
            // Bits still owed after this clock's issue mean the previous frame
            // had not drained; coinciding due bits coalesce.
            pending_d = pending_left | due;
            if (pending_left != '0) begin
                overrun_d = 1'b1;
            end
            start_d = ptr_q;
            ptr_d   = (ptr_q == IDX_W'(N_SQ - 1)) ? '0 : ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            anim_q     <= 1'b0;
            step_req_q <= 1'b0;
            pending_q  <= '0;
            sq_q       <= '0;
            ptr_q      <= '0;
            start_q    <= '0;
            frame_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (i_pix_stb) begin
                anim_q <= i_animate;
            end
            step_req_q <= step_req_d;
            pending_q  <= pending_d;
            sq_q       <= sq_d;
            ptr_q      <= ptr_d;
            start_q    <= start_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_sq_animate = sq_q;
    assign o_frame      = frame_q;
    assign o_busy       = |pending_q;
    assign o_paused     = (state_q == ST_PAUSED);
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed bench for anim_scheduler with default parameters
// (N_SQ=3, DIVS=12'h121: sq0 and sq2 every frame, sq1 every second frame).
// Pulses are logged on the falling edge as a nibble sequence (square index+1).
module tb_anim_scheduler;

    localparam int N_SQ    = 3;
    localparam int FRAME_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pix_stb = 1'b1;
    logic               animate = 1'b0;
    logic               pause = 1'b0;
    logic               step = 1'b0;
    logic [N_SQ-1:0]    sq;
    logic [FRAME_W-1:0] frame;
    logic               busy, paused, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ev_cyc = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int seq = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    anim_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_pix_stb    (pix_stb),
        .i_animate    (animate),
        .i_pause      (pause),
        .i_step       (step),
        .o_sq_animate (sq),
        .o_frame      (frame),
        .o_busy       (busy),
        .o_paused     (paused),
        .o_overrun    (overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sq != '0) begin
            int id;
            id = 0;
            chk("onehot", $countones(sq), 1);
            for (int i = 0; i < N_SQ; i++) if (sq[i]) id = i;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            seq = (seq << 4) | (id + 1);
        end
    end

    task automatic clear_log();
        seq = 0;
        first_cyc = -1;
        last_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event in the current cycle, then one low strobe cycle to re-arm.
    task automatic frame_evt();
        animate = 1'b1;
        ev_cyc = cyc;
        tick();
        animate = 1'b0;
        tick();
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic do_frame(input string tag, input int exp_seq, input int exp_frame);
        clear_log();
        frame_evt();
        drain();
        chk({tag, "_seq"}, seq, exp_seq);
        chk({tag, "_frame"}, int'(frame), exp_frame);
        $display("frame %s: seq=%0h o_frame=%0d", tag, seq, frame);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_sq", int'(sq), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // First event only aligns
        do_frame("align", 0, 0);

        // Frame 1: start 0, sq1 not yet due -> sq0, sq2 contiguous from T+2
        clear_log();
        frame_evt();
        chk("busy_mid", int'(busy), 1);
        drain();
        chk("f1_seq", seq, 'h13);
        chk("f1_first", first_cyc - ev_cyc, 2);
        chk("f1_last", last_cyc - ev_cyc, 3);
        chk("f1_frame", int'(frame), 1);
        chk("f1_busy", int'(busy), 0);
        $display("frame f1: seq=%0h o_frame=%0d", seq, frame);

        // Divider cadence and rotating start index
        do_frame("f2", 'h231, 2);
        do_frame("f3", 'h31, 3);
        do_frame("f4", 'h123, 4);

        // Pause and single step
        pause = 1'b1;
        tick();
        chk("paused_on", int'(paused), 1);
        do_frame("p1", 0, 4);
        do_frame("p2", 0, 4);
        step = 1'b1;
        tick();
        step = 1'b0;
        do_frame("step", 'h31, 5);
        chk("paused_still", int'(paused), 1);
        do_frame("p3", 0, 5);

        // Held animate is one event; toggling without strobe is none
        pause = 1'b0;
        tick();
        chk("paused_off", int'(paused), 0);
        clear_log();
        animate = 1'b1;
        ev_cyc = cyc;
        repeat (8) tick();
        animate = 1'b0;
        tick();
        pix_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            animate = ~animate;
            tick();
        end
        animate = 1'b0;
        tick();
        pix_stb = 1'b1;
        drain();
        chk("hold_seq", seq, 'h312);
        chk("hold_first", first_cyc - ev_cyc, 2);
        chk("hold_frame", int'(frame), 6);
        $display("frame hold: seq=%0h o_frame=%0d", seq, frame);

        do_frame("f7", 'h13, 7);
        chk("no_overrun", int'(overrun), 0);

        // Overrun: second event two cycles after an all-due frame
        clear_log();
        animate = 1'b1;
        tick();
        animate = 1'b0;
        tick();
        animate = 1'b1;
        tick();
        animate = 1'b0;
        drain();
        chk("ovr_seq", seq, 'h2331);
        chk("ovr_frame", int'(frame), 9);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_busy", int'(busy), 0);
        $display("frame overrun: seq=%0h o_frame=%0d overrun=%0d", seq, frame, overrun);

        // Reset during a 3-pulse frame
        clear_log();
        animate = 1'b1;
        ev_cyc = cyc;
        tick();
        animate = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sq", int'(sq), 0);
        chk("mid_rst_frame", int'(frame), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        drain();
        chk("mid_rst_seq", seq, 'h1);
        $display("frame reset: seq=%0h o_frame=%0d", seq, frame);

        do_frame("realign", 0, 0);
        do_frame("post_rst", 'h13, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
